mem_arb: RTL
============

# mem_arb

Two-requester round-robin arbiter and sequencer for a single-clock instance of the team's simple dual-port RAM (registered read, one-cycle read latency). Requesters A and B each issue read or write commands through a req/gnt handshake. The arbiter grants at most one command per cycle and registers it onto the RAM write or read port. It then routes the returned read data back to the owner with an rvalid strobe. It sits between the two client engines and the RAM, whose wr_clk and rd_clk are tied to the same clock.

## Interface
- DATA_WIDTH, 8, width of wdata/rdata
- ADDR_WIDTH, 8, width of addresses

- clk  input  1  single clock; RAM wr_clk/rd_clk tied to it
- rst  input  1  asynchronous, active-high reset
- req_a / req_b  input  1  command request, held until granted
- we_a / we_b  input  1  1 = write, 0 = read; valid with req
- addr_a / addr_b  input  ADDR_WIDTH  command address
- wdata_a / wdata_b  input  DATA_WIDTH  write data
- gnt_a / gnt_b  output  1  combinational grant; command accepted at this edge
- rvalid_a / rvalid_b  output  1  registered read-return strobe
- rdata_a / rdata_b  output  DATA_WIDTH  equal to mem_rdata; meaningful only while the matching rvalid is high
- mem_wr_en  output  1  registered RAM write enable
- mem_waddr  output  ADDR_WIDTH  registered RAM write address
- mem_wdata  output  DATA_WIDTH  registered RAM write data
- mem_rd_en  output  1  registered RAM read enable
- mem_raddr  output  ADDR_WIDTH  registered RAM read address
- mem_rdata  input  DATA_WIDTH  RAM read data; updates one edge after mem_rd_en

## Operation
- **Priority pointer `prio`** (1 bit; 0 = A preferred, 1 = B preferred). Reset value 0.
- **Grant rule:**
  - gnt_a = req_a & (~req_b | ~prio).
  - gnt_b = req_b & (~req_a | prio).
  - At most one grant per cycle. No grant when neither requests.
- **Pointer update:** on any grant, prio <= 1 if A was granted, 0 if B was granted. With no grant, prio holds. A lone requester is granted every cycle.
- **Command stage:** on the edge where gnt_x=1, the granted command is registered onto the RAM ports.
  - Write: mem_wr_en<=1, mem_waddr<=addr_x, mem_wdata<=wdata_x, mem_rd_en<=0.
  - Read: mem_rd_en<=1, mem_raddr<=addr_x, mem_wr_en<=0.
  - With no grant, both enables are 0.
  - Address and data registers hold their last value when not enabled.
- **Return pipeline:** a 2-stage owner shift register (valid bit + owner id).
  - Stage 1 loads on a read grant.
  - Stage 2 drives rvalid_a / rvalid_b.
  - Writes never produce rvalid.
- **Ordering:** commands execute strictly in grant order. A write granted at cycle t followed by a read of the same address granted at t+1 returns the new data, because the RAM write lands at the edge ending t+1 and the read samples at the edge ending t+2.
- **Reset** (asynchronous, any time):
  - prio=0; mem_wr_en=0, mem_rd_en=0; mem_waddr, mem_raddr, mem_wdata = 0; pipeline valid bits = 0; rvalid_a = rvalid_b = 0.
  - In-flight reads are dropped and never return.
  - gnt_* are combinational and follow req_* during reset; requests granted while rst is high are discarded.
- Requesters must hold req, we, addr and wdata stable until gnt.

## Timing
- Grant: same cycle as req (combinational), effective at the next rising edge.
- Write: mem_wr_en high in cycle t+1 for a grant in cycle t. RAM contents update at the edge ending t+1.
- Read: mem_rd_en high in t+1. mem_rdata valid in t+2. rvalid_x high in t+2 for exactly one cycle per granted read.
- Throughput: one command per cycle, combined across both requesters. Back-to-back reads give back-to-back rvalid pulses in grant order.
- Worst-case wait for a continuously requesting client: 1 cycle.

## Test plan
- **Reset values:** assert rst mid-stream with a read in flight.
  - All registered outputs go 0 immediately. No rvalid pulse appears for the dropped read.
  - After release, prio=0.
- **Single write then read (A):**
  - Cycle 0: req_a=1, we_a=1, addr_a=0x10, wdata_a=0x5A. Expect gnt_a=1 and mem_wr_en=1 in cycle 1.
  - Cycle 1: read of 0x10 → mem_rd_en=1 in cycle 2, rvalid_a=1 with rdata_a=0x5A in cycle 3, rvalid_b=0.
- **Contention:** req_a and req_b held high for 6 cycles, all reads.
  - Grants alternate A,B,A,B,A,B starting with A.
  - rvalid pulses alternate A,B,... starting 2 cycles after the first grant.
- **Lone requester:** req_b=1 for 4 cycles with req_a=0.
  - gnt_b=1 all 4 cycles.
  - Then raise req_a with both requesting: A is granted first, since prio=0 after the B grants.
- **Mixed traffic:** A writes 0xC3 to 0xFF while B reads 0xFF.
  - With prio=0, A's write is granted first and B's read next.
  - B receives rdata_b=0xC3, proving ordering and wrap to the top address.
- **Idle hold:** no requests for 3 cycles.
  - mem_wr_en = mem_rd_en = 0.
  - mem_waddr, mem_raddr, mem_wdata and prio unchanged.

Source files
------------

// File: rtl/mem_arb_if.sv
// mem_arb_if: client command/return signals for requesters A and B plus the RAM port bundle.
interface mem_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_a, req_b;
    logic                  we_a, we_b;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b;
    logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
    logic                  gnt_a, gnt_b;
    logic                  rvalid_a, rvalid_b;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
               mem_wr_en, mem_waddr, mem_wdata, mem_rd_en, mem_raddr
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
               mem_wr_en, mem_waddr, mem_wdata, mem_rd_en, mem_raddr
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-requester round-robin arbiter sequencing commands onto a registered-read RAM
// and returning read data to the owner two cycles after grant.
module mem_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    mem_arb_if.slave   bus
);
    logic                  r_prio;
    logic                  r_wr_en, r_rd_en;
    logic [ADDR_WIDTH-1:0] r_waddr, r_raddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_v1, r_o1;
    logic                  r_rv_a, r_rv_b;
    logic                  w_gnt_a, w_gnt_b, w_gnt, w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    always_comb begin
        w_gnt_a = bus.req_a & (~bus.req_b | ~r_prio);
        w_gnt_b = bus.req_b & (~bus.req_a | r_prio);
        w_gnt   = w_gnt_a | w_gnt_b;
        w_we    = w_gnt_a ? bus.we_a    : bus.we_b;
        w_addr  = w_gnt_a ? bus.addr_a  : bus.addr_b;
        w_wdata = w_gnt_a ? bus.wdata_a : bus.wdata_b;
    end

    // Owner pipeline: stage 1 tracks the read on the RAM port, stage 2 aligns with mem_rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_waddr <= '0;
            r_raddr <= '0;
            r_wdata <= '0;
            r_v1    <= 1'b0;
            r_o1    <= 1'b0;
            r_rv_a  <= 1'b0;
            r_rv_b  <= 1'b0;
        end else begin
            if (w_gnt) r_prio <= w_gnt_a;
            r_wr_en <= w_gnt & w_we;
            r_rd_en <= w_gnt & ~w_we;
            if (w_gnt & w_we) begin
                r_waddr <= w_addr;
                r_wdata <= w_wdata;
            end
            if (w_gnt & ~w_we) r_raddr <= w_addr;
            r_v1   <= w_gnt & ~w_we;
            r_o1   <= w_gnt_b;
            r_rv_a <= r_v1 & ~r_o1;
            r_rv_b <= r_v1 & r_o1;
        end
    end

    assign bus.gnt_a     = w_gnt_a;
    assign bus.gnt_b     = w_gnt_b;
    assign bus.mem_wr_en = r_wr_en;
    assign bus.mem_waddr = r_waddr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_rd_en = r_rd_en;
    assign bus.mem_raddr = r_raddr;
    assign bus.rvalid_a  = r_rv_a;
    assign bus.rvalid_b  = r_rv_b;
    assign bus.rdata_a   = bus.mem_rdata;
    assign bus.rdata_b   = bus.mem_rdata;
endmodule
